// File: rtl/add_pipe.sv
// add_pipe: elastic STAGES-deep pipelined adder with valid/ready handshake on both sides.
// Define ADD_PIPE_SAT_EN to saturate to all-ones on carry instead of exposing the carry bit.
module add_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH:0]    sum_q [STAGES];
    logic [WIDTH:0]    sum_d [STAGES];

    logic [STAGES-1:0] load;
    logic              loadChain;
    logic [WIDTH:0]    rawSum;
    logic [WIDTH:0]    inSum;
    logic [STAGES:0]   chainValid;
    logic [WIDTH:0]    chainSum [STAGES+1];

    always_comb begin
        rawSum = {1'b0, a} + {1'b0, b};
`ifdef ADD_PIPE_SAT_EN
        inSum = rawSum[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : rawSum;
`else
        inSum = rawSum;
`endif
    end

    // A stage may load when it, or any stage downstream of it, is empty,
    // or when the consumer drains the last stage this cycle.
    always_comb begin
        load      = '0;
        loadChain = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            loadChain = loadChain | ~valid_q[k];
            load[k]   = loadChain;
        end
    end

    always_comb begin
        chainValid  = {valid_q, in_valid};
        chainSum[0] = inSum;
        for (int k = 0; k < STAGES; k++) begin
            chainSum[k+1] = sum_q[k];
        end
    end

    // Sum data only moves with a valid token so empty stages keep their old value.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = sum_q[k];
            if (load[k]) begin
                valid_d[k] = chainValid[k];
                if (chainValid[k]) begin
                    sum_d[k] = chainSum[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];

endmodule
